mem_stall_ctrl: RTL and testbench
=================================

# mem_stall_ctrl

Sequencer for the MEM stage when data memory is a multi-cycle slave with a req/ack handshake. It sits between the EX/MEM pipeline register outputs and the data memory port, and issues one memory transaction per load/store. It freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) with `stall_o` until the access completes, then presents the load data for one cycle to MEM/WB. It also enforces an ack timeout and counts stall cycles for performance debug.

## Interface
- `TIMEOUT`, default 64: maximum cycles in BUSY without `mem_ack_i` before the access is aborted; legal range 2..65535.
- `CNT_W`, default 32: width of the stall-cycle counter.

- `clk_i`  in  1  single clock, all state changes on rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `MemRead_i`  in  1  load in MEM stage (from EX/MEM).
- `MemWrite_i`  in  1  store in MEM stage (from EX/MEM).
- `addr_i`  in  32  ALU result = byte address (from EX/MEM).
- `wdata_i`  in  32  store data (from EX/MEM).
- `mem_req_o`  out  1  request to data memory, level, held until ack.
- `mem_we_o`  out  1  1 = write, valid while `mem_req_o`.
- `mem_addr_o`  out  32  latched address.
- `mem_wdata_o`  out  32  latched store data.
- `mem_ack_i`  in  1  one-cycle completion pulse from memory.
- `mem_rdata_i`  in  32  read data, valid with `mem_ack_i`.
- `stall_o`  out  1  freeze PC and IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- `rdata_o`  out  32  load result to MEM/WB, valid when `done_o`.
- `done_o`  out  1  access completes this cycle; pipeline advances.
- `err_o`  out  1  sticky timeout flag.
- `stall_cnt_o`  out  CNT_W  saturating count of cycles with `stall_o`=1.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE: an access is requested when `MemRead_i|MemWrite_i`.
  - On a request, `stall_o`=1 combinationally.
  - At the edge, latch `addr_i`, `wdata_i`, and we=`MemWrite_i`, then go to BUSY.
  - With no request: `stall_o`=0 and `done_o`=0.
- Both `MemRead_i` and `MemWrite_i` high: handled as a write.
- BUSY: `mem_req_o`=1 and `stall_o`=1. Address, data and we are stable for the whole state.
  - On `mem_ack_i`=1: latch `mem_rdata_i` into `rdata_o`; for a write, latch 0. Go to DONE.
  - Timeout counter starts at 0 on entry and increments each BUSY cycle without ack.
  - If the counter reaches TIMEOUT-1 with no ack: drop the request, set `err_o`, `rdata_o`=0, go to DONE.
  - Ack in the same cycle as the timeout: ack wins, `err_o` is not set.
- DONE: `done_o`=1, `stall_o`=0, `mem_req_o`=0; the pipeline advances at this edge. Next state is IDLE unconditionally.
  - The instruction now in EX/MEM is evaluated in the following IDLE cycle, so back-to-back accesses each get a full sequence.
- `mem_ack_i` in IDLE or DONE is ignored. No state change; data is not latched.
- `stall_cnt_o` increments on every cycle with `stall_o`=1 and saturates at all-ones.
- `err_o` stays set until reset.
- Reset mid-access: `mem_req_o` drops at the reset edge, FSM returns to IDLE, and the transaction is abandoned. The memory must tolerate a withdrawn request.
- Reset values: `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `stall_o`=0, `rdata_o`=0, `done_o`=0, `err_o`=0, `stall_cnt_o`=0.

## Timing
- `stall_o` and `done_o` are combinational from state and inputs. All other outputs are registered.
- Minimum sequence, ack in the first BUSY cycle: IDLE (stall) → BUSY (stall, req, ack) → DONE. That is 2 stall cycles and done in cycle 3.
- Ack after N BUSY cycles gives N+1 stall cycles.
- Timeout gives TIMEOUT+1 stall cycles, then DONE with `err_o`=1 in the DONE cycle.
- Non-memory instructions see zero added latency.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - default TIMEOUT constant;
  - `RDATA_ABORT` = 32'h0 constant.
- One sub-module, `sat_counter` (parameter width; inputs clk, synchronous reset, en; output count; saturating). It is used for `stall_cnt_o`.
- The timeout counter is inline: width = clog2(TIMEOUT).

## Test plan
- Load, addr=0x0000_0010, ack in first BUSY cycle with rdata=0xCAFE_F00D:
  - `stall_o` high for exactly 2 cycles;
  - `done_o` pulses once with `rdata_o`=0xCAFE_F00D;
  - `stall_cnt_o`=2.
- Store, wdata=0x1234_5678, ack after 5 BUSY cycles:
  - `mem_we_o`=1 and addr/data stable throughout;
  - 6 stall cycles; `rdata_o`=0.
- No ack, TIMEOUT=8:
  - request dropped after 8 BUSY cycles;
  - `err_o`=1 from DONE onward and held through later accesses;
  - `rdata_o`=0.
- Back-to-back load then store:
  - two complete IDLE→BUSY→DONE sequences;
  - a stray `mem_ack_i` injected in DONE is ignored.
- `rst_i` asserted in the 3rd BUSY cycle:
  - next cycle `mem_req_o`=0, `stall_o`=0, IDLE;
  - all outputs and `stall_cnt_o` are 0.
- Both `MemRead_i` and `MemWrite_i` high: `mem_we_o`=1; ack in the timeout cycle leaves `err_o`=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding and constants for the MEM-stage memory sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 64;

  // Value returned to MEM/WB for stores and for aborted (timed-out) accesses.
  localparam logic [31:0] RDATA_ABORT = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; en_i is sampled every cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: increment when enabled unless already saturated.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer: one req/ack memory transaction per load/store, pipeline frozen meanwhile.
// Latency: ack in BUSY cycle N gives N+1 stall cycles, done_o the cycle after; timeout gives TIMEOUT+1.
// Backpressure: stall_o holds PC..EX/MEM until the access completes; mem_req_o held until ack or timeout.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             stall_o,
  output logic [31:0]      rdata_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  // Next state, latched transaction fields, and the combinational stall/done strobes.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MemRead_i || MemWrite_i) begin
          stall_o  = 1'b1;
          state_d  = BUSY;
          req_d    = 1'b1;
          // Read+write together is treated as a write.
          we_d     = MemWrite_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          to_cnt_d = '0;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          // Ack beats a simultaneous timeout; stores return zero.
          rdata_d = we_q ? RDATA_ABORT : mem_rdata_i;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (to_cnt_q == TO_LAST) begin
          rdata_d = RDATA_ABORT;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        // Pipeline advances at this edge; the next EX/MEM op is looked at in IDLE.
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (stall_o),
    .count_o(stall_cnt_o)
  );

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: directed scenarios followed by random loads/stores against a transaction model.
// Latency: n/a.
// Backpressure: bench acts as the data memory, acking after a chosen number of request cycles.
module tb_mem_stall_ctrl;

  localparam int TO      = 8;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    int          cnt;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          MemRead_i, MemWrite_i;
  logic [31:0]   addr_i, wdata_i;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic          stall_o, done_o, err_o;
  logic [31:0]   rdata_o;
  logic [CW-1:0] stall_cnt_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_tot = 0;
  logic m_err = 1'b0;
  int   stall_run = 0;
  int   req_run = 0;

  always #5 clk_i = ~clk_i;

  mem_stall_ctrl #(
    .TIMEOUT(TO),
    .CNT_W  (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Transaction-level model: outcome depends only on op type and ack delay.
  task automatic push_exp(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int ack_at, input logic [31:0] rv);
    exp_t e;
    int   busy;
    logic tmo;
    tmo   = (ack_at < 1) || (ack_at > TO);
    busy  = tmo ? TO : ack_at;
    m_err = m_err | tmo;
    m_tot = m_tot + busy + 1;
    e.we     = wr;
    e.addr   = a;
    e.wdata  = d;
    e.rdata  = (tmo || wr) ? 32'h0 : rv;
    e.err    = m_err;
    e.stalls = busy + 1;
    e.cnt    = (m_tot > CNT_MAX) ? CNT_MAX : m_tot;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int ack_at, input logic [31:0] rv, input logic stray);
    int busy = 0;
    push_exp(wr, a, d, ack_at, rv);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
    for (int n = 0; n <= TO + 4; n++) begin
      if (mem_req_o) begin
        busy++;
        mem_ack_i   = (busy == ack_at);
        mem_rdata_i = (busy == ack_at) ? rv : $urandom;
      end else begin
        mem_ack_i   = stray;
        mem_rdata_i = $urandom;
      end
      if (done_o) begin
        @(posedge clk_i); #1;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL txn_complete: done_o not seen within %0d cycles", TO + 5);
    summary();
    $fatal(1, "access never completed");
  endtask

  task automatic idle(input int n, input logic stray);
    repeat (n) begin
      mem_ack_i   = stray;
      mem_rdata_i = $urandom;
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
  endtask

  // Load with no ack, reset asserted during its third BUSY cycle.
  task automatic reset_mid_access();
    int          busy = 0;
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom | 32'h1;
    d = $urandom;
    push_exp(1'b0, a, d, TO + 5, 32'h0);
    MemRead_i = 1'b1;
    addr_i    = a;
    wdata_i   = d;
    mem_ack_i = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (mem_req_o) busy++;
      if (busy == 3) break;
      @(posedge clk_i); #1;
    end
    chk("reached_busy3", busy, 3);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    exp_q.delete();
    m_tot = 0;
    m_err = 1'b0;
    @(negedge clk_i);
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    @(posedge clk_i); #1;
  endtask

  // Monitor: checks the memory port against the pending access and scores each completion.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_i) begin
      stall_run = 0;
      req_run   = 0;
    end else begin
      if (stall_o) stall_run++;
      if (mem_req_o) begin
        req_run++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_without_access: mem_req_o=1, expected 0 at %0t", $time);
        end else begin
          chk("mem_addr", mem_addr_o, exp_q[0].addr);
          chk("mem_we", mem_we_o, exp_q[0].we);
          chk("mem_wdata", mem_wdata_o, exp_q[0].wdata);
        end
      end
      if (exp_q.size() == 0) chk("no_access_stall", stall_o, 0);
      if (done_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_without_access: done_o=1, expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata_o, e.rdata);
          chk("err", err_o, e.err);
          chk("stall_cnt", stall_cnt_o, e.cnt);
          chk("stall_cycles", stall_run, e.stalls);
          chk("req_cycles", req_run, e.stalls - 1);
          chk("done_req_low", mem_req_o, 0);
        end
        stall_run = 0;
        req_run   = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int op;
    rst_i       = 1'b1;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("init_req", mem_req_o, 0);
    chk("init_stall", stall_o, 0);
    chk("init_done", done_o, 0);
    chk("init_err", err_o, 0);
    chk("init_cnt", stall_cnt_o, 0);
    chk("init_rdata", rdata_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Minimum-latency load.
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
    idle(2, 1'b0);
    // Store acked after 5 BUSY cycles.
    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 5, 32'hDEAD_BEEF, 1'b0);
    idle(1, 1'b0);
    // No ack at all: timeout, sticky error.
    run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, TO + 5, 32'h5555_AAAA, 1'b0);
    // Back-to-back load then store with stray acks outside BUSY.
    run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3, 32'h0BAD_CAFE, 1'b1);
    run_txn(1'b0, 1'b1, 32'h0000_0304, 32'hA5A5_5A5A, 2, 32'h1111_2222, 1'b1);
    idle(2, 1'b1);
    // Reset in the middle of an access.
    reset_mid_access();
    // Read and write together, ack in the timeout cycle.
    run_txn(1'b1, 1'b1, 32'h0000_0400, 32'h8765_4321, TO, 32'h3333_4444, 1'b0);
    idle(1, 1'b0);

    // Random mix; delays beyond TO produce timeouts, stall counter saturates.
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 2));
      run_txn(op != 1, op != 0, $urandom, $urandom, int'($urandom_range(1, TO + 2)),
              $urandom, 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    idle(3, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
